// File: rtl/cesa_arb_pkg.sv
// cesa_arb_pkg -- shared definitions for the two-port shared-adder arbiter.
//   OP_W    : operand width fed to the shared adder
//   RES_W   : result width (operand width plus carry-out)
//   state_e : arbiter FSM states
package cesa_arb_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    INC  = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/cesa32_4.sv
// cesa32_4 -- 32-bit carry-select adder built from eight 4-bit blocks.
// Each block precomputes its sum for carry-in 0 and 1; the ripple of block
// carries only drives the select muxes.
// Ports:
//   a_i, b_i : 32-bit operands
//   cin_i    : carry-in
//   sum_o    : 32-bit sum
//   cout_o   : carry-out
module cesa32_4 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [8:0] carry;

  assign carry[0] = cin_i;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_blk
      logic [4:0] sum_c0;
      logic [4:0] sum_c1;

      assign sum_c0 = {1'b0, a_i[4*gi +: 4]} + {1'b0, b_i[4*gi +: 4]};
      // a + b + 1 never exceeds 5 bits for 4-bit operands.
      assign sum_c1 = sum_c0 + 5'd1;

      assign sum_o[4*gi +: 4] = carry[gi] ? sum_c1[3:0] : sum_c0[3:0];
      assign carry[gi+1]      = carry[gi] ? sum_c1[4]   : sum_c0[4];
    end
  endgenerate

  assign cout_o = carry[8];

endmodule

// File: rtl/cesa_arbiter.sv
// cesa_arbiter -- round-robin arbiter sharing one 32-bit adder between two
// requesters. One operation is in flight at a time:
//   IDLE -> EXEC -> RESP           (add)
//   IDLE -> EXEC -> INC -> RESP    (sub, only with CESA_ARB_SUB_EN)
// Subtraction is a + ~b in EXEC followed by +1 in INC; the result carry is
// the OR of both carries.
// Build option: define CESA_ARB_SUB_EN to honour reqN_sub_i; otherwise every
// operation is an add and the INC state is not built.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   reqN_valid_i / reqN_ready_o   : request handshake for port N (0/1)
//   reqN_a_i, reqN_b_i, reqN_sub_i: operands and operation for port N
//   rsp_valid_o / rsp_ready_i     : response handshake
//   rsp_sum_o                     : 33-bit result, bit 32 = carry-out
//   rsp_src_o                     : port that issued the result
// Parameter RESET_PRIO: port holding priority after reset (0 or 1).
module cesa_arbiter
  import cesa_arb_pkg::*;
#(
  parameter int RESET_PRIO = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [OP_W-1:0]  req0_a_i,
  input  logic [OP_W-1:0]  req0_b_i,
  input  logic             req0_sub_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [OP_W-1:0]  req1_a_i,
  input  logic [OP_W-1:0]  req1_b_i,
  input  logic             req1_sub_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [RES_W-1:0] rsp_sum_o,
  output logic             rsp_src_o
);

  state_e            state_reg, state_next;
  logic              prio_reg, prio_next;
  logic              src_reg, src_next;
  logic [OP_W-1:0]   a_reg, a_next;
  logic [OP_W-1:0]   b_reg, b_next;
  logic [RES_W-1:0]  result_reg, result_next;
`ifdef CESA_ARB_SUB_EN
  logic              sub_reg, sub_next;
`else
  logic              unused_sub;
  assign unused_sub = req0_sub_i ^ req1_sub_i;
`endif

  logic              winner;
  logic [OP_W-1:0]   add_a, add_b, add_sum;
  logic              add_cout;

  // Lone requester wins; on a tie the priority pointer decides.
  assign winner = (req0_valid_i && req1_valid_i) ? prio_reg : req1_valid_i;

  cesa32_4 u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_next   = state_reg;
    prio_next    = prio_reg;
    src_next     = src_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    result_next  = result_reg;
`ifdef CESA_ARB_SUB_EN
    sub_next     = sub_reg;
`endif
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    add_a        = a_reg;
    add_b        = b_reg;

    case (state_reg)
      IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          // Gated by rst_ni so no handshake is signalled while in reset.
          req0_ready_o = rst_ni && !winner;
          req1_ready_o = rst_ni && winner;
          a_next       = winner ? req1_a_i : req0_a_i;
          b_next       = winner ? req1_b_i : req0_b_i;
`ifdef CESA_ARB_SUB_EN
          sub_next     = winner ? req1_sub_i : req0_sub_i;
`endif
          src_next     = winner;
          prio_next    = !winner;
          state_next   = EXEC;
        end
      end
      EXEC: begin
`ifdef CESA_ARB_SUB_EN
        add_b       = sub_reg ? ~b_reg : b_reg;
        state_next  = sub_reg ? INC : RESP;
`else
        state_next  = RESP;
`endif
        result_next = {add_cout, add_sum};
      end
`ifdef CESA_ARB_SUB_EN
      INC: begin
        add_a       = result_reg[OP_W-1:0];
        add_b       = 32'd1;
        result_next = {result_reg[OP_W] | add_cout, add_sum};
        state_next  = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'(RESET_PRIO);
      src_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
`ifdef CESA_ARB_SUB_EN
      sub_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      prio_reg   <= prio_next;
      src_reg    <= src_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      result_reg <= result_next;
`ifdef CESA_ARB_SUB_EN
      sub_reg    <= sub_next;
`endif
    end
  end

  assign rsp_valid_o = (state_reg == RESP);
  assign rsp_sum_o   = result_reg;
  assign rsp_src_o   = src_reg;

endmodule

// File: doc/cesa_arbiter.md
CESA_ARBITER -- requirements
Module: cesa_arbiter

Interface
REQ-001 Parameter: RESET_PRIO, default 0, index of the port holding priority after reset (0 or 1).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid_i / req1_valid_i  input  1  request pending on port 0 / 1.
REQ-005 req0_ready_o / req1_ready_o  output  1  request accepted this cycle (handshake = valid & ready).
REQ-006 req0_a_i, req0_b_i / req1_a_i, req1_b_i  input  32  operands.
REQ-007 req0_sub_i / req1_sub_i  input  1  1 = a-b, 0 = a+b (effective only with CESA_ARB_SUB_EN).
REQ-008 rsp_valid_o  output  1  result available.
REQ-009 rsp_ready_i  input  1  consumer accepts result.
REQ-010 rsp_sum_o  output  33  result; bit 32 = carry-out.
REQ-011 rsp_src_o  output  1  port index that issued the result.

Function
REQ-012 The block shall time-share one 32-bit adder (fixed carry-in 0) between two requesters; only one operation is in flight at any time.
REQ-013 FSM states: IDLE, EXEC, INC, RESP; reset state IDLE.
REQ-014 IDLE: if any valid, assert ready only for the winner, register operands, op and source; go to EXEC. No valid: stay in IDLE.
REQ-015 Arbitration: single valid wins; both valid -> priority-pointer port wins; after every grant, pointer moves to the other port (round-robin).
REQ-016 ready_o shall be 0 in all states other than IDLE, and 0 to the loser in IDLE.
REQ-017 EXEC: adder input is (a, b) for add or (a, ~b) for sub; sum registered into result reg; add -> RESP, sub -> INC.
REQ-018 INC: adder input is (result[31:0], 32'h1); result[31:0] gets new sum; result[32] = carry of EXEC OR carry of INC; go to RESP.
REQ-019 RESP: rsp_valid_o = 1; result and src held stable until rsp_ready_i = 1, then go to IDLE.
REQ-020 Latency handshake -> rsp_valid_o: add 2 cycles, sub 3 cycles; throughput one op per 3 (add) or 4 (sub) cycles when rsp_ready_i is held at 1.
REQ-021 rsp_valid_o shall be 0 in IDLE, EXEC and INC; a request arriving during a busy state waits and is not dropped.
REQ-022 Request inputs are ignored outside IDLE; changes to valid or operands there have no effect.

Reset
REQ-023 Reset shall, asynchronously, set: state IDLE, rsp_valid_o 0, rsp_sum_o 0, rsp_src_o 0, ready outputs 0, priority pointer RESET_PRIO.
REQ-024 Reset during any state aborts the operation in flight; no response is produced for it.

Configuration
REQ-025 Macro CESA_ARB_SUB_EN defined: sub_i is honoured as in REQ-017/018.
REQ-026 Macro undefined: sub_i is ignored, every op is an add, state INC and its logic are absent.

Structure
REQ-027 Package cesa_arb_pkg shall hold the FSM state enum, operand width (32) and result width (33) constants.
REQ-028 Exactly one sub-module: the existing cesa32_4 adder, instantiated once; the operand mux sits in front of it.

Verification
REQ-029 Port 0 only, a=32'hFFFF_FFFF, b=1, add -> rsp_sum 33'h1_0000_0000, src 0, rsp_valid 2 cycles after handshake.
REQ-030 Both ports valid in the same cycle, held for 4 ops after reset (RESET_PRIO=0) -> grant order 0,1,0,1; all four results correct.
REQ-031 SUB_EN: a=10, b=3, sub -> rsp_sum[31:0]=7, bit32=1, latency 3; a=3, b=10 -> 32'hFFFF_FFF9, bit32=0.
REQ-032 rsp_ready_i held 0 for 5 cycles in RESP -> rsp_sum and src stable, both req ready 0, port 1 request pending then served in the next IDLE.
REQ-033 rst_ni asserted in EXEC -> rsp_valid 0, state IDLE, pointer RESET_PRIO; no stale response after release.
REQ-034 SUB_EN undefined: sub_i=1, a=10, b=3 -> rsp_sum 13, latency 2.
